// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
//   Shared constants and types for the fifo_ctrl slice.
//   - DEFAULT_DATA_WIDTH / DEFAULT_ADDR_WIDTH : default payload and storage
//     address widths used by the interface and the controller.
//   - buf_cnt_t : occupancy count of the 2-entry output buffer (0..2).
//   - buf_op_e  : capture/pop combination seen by the output buffer.
// ---------------------------------------------------------------------------
package fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_ADDR_WIDTH = 10;

    // Output buffer holds at most two words: one being presented and one
    // landing from the storage read pipeline.
    localparam int OUT_BUF_DEPTH = 2;

    typedef logic [1:0] buf_cnt_t;

    // Encoding is {capture, pop} so it can be cast straight from the strobes.
    typedef enum logic [1:0] {
        BUF_IDLE    = 2'b00,
        BUF_POP     = 2'b01,
        BUF_CAPTURE = 2'b10,
        BUF_BOTH    = 2'b11
    } buf_op_e;

endpackage : fifo_pkg

// File: rtl/fifo_if.sv
// ---------------------------------------------------------------------------
// fifo_if
//   Valid/ready word stream used on both sides of fifo_ctrl.
//   Signals : valid (word offered), data (word), ready (word taken).
//   Modports: master drives valid/data and samples ready;
//             slave samples valid/data and drives ready.
// ---------------------------------------------------------------------------
interface fifo_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
    logic                  ready;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );

endinterface : fifo_if

// File: rtl/fifo_out_buf.sv
// ---------------------------------------------------------------------------
// fifo_out_buf
//   Two-entry output skid buffer sitting behind the one-cycle storage read.
//   head_q is the oldest word and drives data directly from a register.
//   Ports:
//     clk, rstn  : clock, asynchronous active-low reset
//     capture    : cap_data is the word returning from storage this cycle
//     cap_data   : returning storage word
//     pop        : downstream takes the head word this cycle (only asserted
//                  while valid)
//     valid      : buffer holds at least one word
//     data       : oldest word (registered)
//     count      : number of words held (0..2)
// ---------------------------------------------------------------------------
module fifo_out_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  capture,
    input  logic [DATA_WIDTH-1:0] cap_data,
    input  logic                  pop,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output buf_cnt_t              count
);

    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] tail_q;
    buf_cnt_t              count_q;
    buf_op_e               op;

    assign op = buf_op_e'({capture, pop});

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others (head_q <= tail_q
    // and tail_q <= cap_data in the same edge must not race).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: the two entries are only two registers, so they are reset;
            // this keeps data at zero during reset. Large storage arrays (the
            // external memory) are never reset.
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            case (op)
                BUF_CAPTURE: begin
                    if (count_q == buf_cnt_t'(0)) begin
                        head_q <= cap_data;
                    end else begin
                        tail_q <= cap_data;
                    end
                    count_q <= count_q + buf_cnt_t'(1);
                end
                BUF_POP: begin
                    head_q  <= tail_q;
                    count_q <= count_q - buf_cnt_t'(1);
                end
                BUF_BOTH: begin
                    // Count is unchanged; the new word goes behind whatever
                    // remains after the head leaves.
                    if (count_q == buf_cnt_t'(1)) begin
                        head_q <= cap_data;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= cap_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign valid = (count_q != buf_cnt_t'(0));
    assign data  = head_q;
    assign count = count_q;

endmodule : fifo_out_buf

// File: rtl/fifo_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_ctrl
//   FIFO controller for an external 1-cycle-read storage array. Tracks write
//   and read pointers plus the stored-word count, issues storage reads ahead
//   of demand, and feeds a 2-entry output buffer so the stream sustains one
//   word per cycle.
//   Ports:
//     clk, rstn  : clock, asynchronous active-low reset
//     in_if      : upstream stream (slave: valid/data in, ready out)
//     out_if     : downstream stream (master: valid/data out, ready in)
//     mem_we, mem_waddr, mem_wdata : storage write port (combinational)
//     mem_re, mem_raddr            : storage read request (combinational)
//     mem_rdata  : storage read data, valid the cycle after mem_re
//     level      : words held = stored + in flight + output buffer
// ---------------------------------------------------------------------------
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    fifo_if.slave                 in_if,
    fifo_if.master                out_if,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_raddr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [ADDR_WIDTH+1:0] level
);

    localparam logic [ADDR_WIDTH:0] DEPTH_V = {1'b1, {ADDR_WIDTH{1'b0}}};

    // Registered state
    logic                  run_q;        // low until the first edge after reset
    logic [ADDR_WIDTH-1:0] wptr_q;
    logic [ADDR_WIDTH-1:0] rptr_q;
    logic [ADDR_WIDTH:0]   mem_count_q;  // words resident in storage
    logic                  inflight_q;   // storage read returning this cycle

    // Per-cycle decisions
    logic                  in_ready;
    logic                  push;
    logic                  pop;
    logic                  rd_issue;
    buf_cnt_t              pending;      // buffered + in-flight words

    // Output buffer view
    logic                  buf_valid;
    logic [DATA_WIDTH-1:0] buf_data;
    buf_cnt_t              buf_count;

    // in_ready depends on registered state only; run_q holds it low while
    // rstn is asserted even though mem_count_q is zero then.
    assign in_ready = run_q && (mem_count_q < DEPTH_V);
    assign push     = in_if.valid && in_ready;
    assign pop      = buf_valid && out_if.ready;
    assign pending  = buf_count + buf_cnt_t'(inflight_q);

    // A read is issued when the buffer will have room for the returning word.
    // mem_count_q excludes this cycle's push, so a word is never read in the
    // cycle it is written.
    // NOTE: every always_comb output gets a default first, so no path through
    // the block leaves it unassigned and no latch is inferred.
    always_comb begin
        rd_issue = 1'b0;
        if (run_q && (mem_count_q != '0)) begin
            if (pending < buf_cnt_t'(OUT_BUF_DEPTH)) begin
                rd_issue = 1'b1;
            end else if ((pending == buf_cnt_t'(OUT_BUF_DEPTH)) && pop) begin
                rd_issue = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            run_q       <= 1'b0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            mem_count_q <= '0;
            inflight_q  <= 1'b0;
        end else begin
            run_q      <= 1'b1;
            inflight_q <= rd_issue;
            if (push) begin
                wptr_q <= wptr_q + ADDR_WIDTH'(1);
            end
            if (rd_issue) begin
                rptr_q <= rptr_q + ADDR_WIDTH'(1);
            end
            case ({push, rd_issue})
                2'b10:   mem_count_q <= mem_count_q + (ADDR_WIDTH+1)'(1);
                2'b01:   mem_count_q <= mem_count_q - (ADDR_WIDTH+1)'(1);
                default: mem_count_q <= mem_count_q;
            endcase
        end
    end

    fifo_out_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_buf (
        .clk      (clk),
        .rstn     (rstn),
        .capture  (inflight_q),
        .cap_data (mem_rdata),
        .pop      (pop),
        .valid    (buf_valid),
        .data     (buf_data),
        .count    (buf_count)
    );

    assign in_if.ready  = in_ready;
    assign out_if.valid = buf_valid;
    assign out_if.data  = buf_data;

    assign mem_we    = push;
    assign mem_waddr = wptr_q;
    assign mem_wdata = in_if.data;
    assign mem_re    = rd_issue;
    assign mem_raddr = rptr_q;

    assign level = {1'b0, mem_count_q}
                 + (ADDR_WIDTH+2)'(inflight_q)
                 + (ADDR_WIDTH+2)'(buf_count);

endmodule : fifo_ctrl

// File: tb/tb_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo_ctrl
//   Self-checking bench for fifo_ctrl with DEPTH=4 and an 8-bit payload,
//   backed by a behavioural 4-word storage array with a 1-cycle read.
// ---------------------------------------------------------------------------
module tb_fifo_ctrl;

    localparam int DW = 8;
    localparam int AW = 2;
    localparam int LW = AW + 2;

    logic          clk;
    logic          rstn;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic          mem_re;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_rdata;
    logic [LW-1:0] level;

    fifo_if #(.DATA_WIDTH(DW)) in_if ();
    fifo_if #(.DATA_WIDTH(DW)) out_if ();

    fifo_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_if     (in_if),
        .out_if    (out_if),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .mem_re    (mem_re),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .level     (level)
    );

    // Storage model: synchronous write, data returned the cycle after mem_re.
    logic [DW-1:0] mem [4];
    always @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_raddr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Inputs for one cycle and the outputs expected before that cycle's edge.
    typedef struct {
        logic          iv;
        logic [DW-1:0] d;
        logic          ordy;
        logic          ir;
        logic          we;
        logic          re;
        logic          ov;
        logic [DW-1:0] od;   // compared only when ov is expected
        logic [LW-1:0] lvl;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic iv, input logic [DW-1:0] d, input logic ordy,
                       input logic ir, input logic we, input logic re,
                       input logic ov, input logic [DW-1:0] od,
                       input logic [LW-1:0] lvl);
        vq.push_back('{iv, d, ordy, ir, we, re, ov, od, lvl});
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rstn         = 1'b0;
        in_if.valid  = 1'b0;
        in_if.data   = '0;
        out_if.ready = 1'b0;
        next_cycle();
        rstn = 1'b1;
        next_cycle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  32'(in_if.ready),  32'd0);
        check({tag, "_out_valid"}, 32'(out_if.valid), 32'd0);
        check({tag, "_out_data"},  32'(out_if.data),  32'd0);
        check({tag, "_mem_we"},    32'(mem_we),       32'd0);
        check({tag, "_mem_re"},    32'(mem_re),       32'd0);
        check({tag, "_level"},     32'(level),        32'd0);
    endtask

    logic [DW-1:0] sb[$];
    logic [DW-1:0] exp_word;
    logic          seen;

    initial begin
        // ---------------- reset values (in_valid held high) ----------------
        rstn         = 1'b0;
        in_if.valid  = 1'b1;
        in_if.data   = 8'hEE;
        out_if.ready = 1'b1;
        next_cycle();
        next_cycle();
        check_reset_outputs("reset");
        in_if.valid  = 1'b0;
        out_if.ready = 1'b0;
        #3;
        rstn = 1'b1;
        next_cycle();
        check("release_in_ready", 32'(in_if.ready), 32'd1);

        // ---------------- table-driven vectors ----------------
        //   iv  d      ordy ir we re ov od     lvl
        // Single word: push, read, in flight, present, popped.
        add(1, 8'h11, 1,   1, 1, 0, 0, 8'h00, 4'd0);
        add(0, 8'h00, 1,   1, 0, 1, 0, 8'h00, 4'd1);
        add(0, 8'h00, 1,   1, 0, 0, 0, 8'h00, 4'd1);
        add(0, 8'h00, 1,   1, 0, 0, 1, 8'h11, 4'd1);
        add(0, 8'h00, 0,   1, 0, 0, 0, 8'h00, 4'd0);
        // Fill with downstream stalled: 6 accepted, 7th refused.
        add(1, 8'hA0, 0,   1, 1, 0, 0, 8'h00, 4'd0);
        add(1, 8'hA1, 0,   1, 1, 1, 0, 8'h00, 4'd1);
        add(1, 8'hA2, 0,   1, 1, 1, 0, 8'h00, 4'd2);
        add(1, 8'hA3, 0,   1, 1, 0, 1, 8'hA0, 4'd3);
        add(1, 8'hA4, 0,   1, 1, 0, 1, 8'hA0, 4'd4);
        add(1, 8'hA5, 0,   1, 1, 0, 1, 8'hA0, 4'd5);
        add(1, 8'hA6, 0,   0, 0, 0, 1, 8'hA0, 4'd6);
        add(0, 8'h00, 0,   0, 0, 0, 1, 8'hA0, 4'd6);
        // Full: push and pop together, push refused, ready returns next cycle.
        add(1, 8'hB0, 1,   0, 0, 1, 1, 8'hA0, 4'd6);
        add(1, 8'hB0, 0,   1, 1, 0, 1, 8'hA1, 4'd5);
        // Drain: order A1..A5 then B0, nothing duplicated or dropped.
        add(0, 8'h00, 1,   0, 0, 1, 1, 8'hA1, 4'd6);
        add(0, 8'h00, 1,   1, 0, 1, 1, 8'hA2, 4'd5);
        add(0, 8'h00, 1,   1, 0, 1, 1, 8'hA3, 4'd4);
        add(0, 8'h00, 1,   1, 0, 1, 1, 8'hA4, 4'd3);
        add(0, 8'h00, 1,   1, 0, 0, 1, 8'hA5, 4'd2);
        add(0, 8'h00, 1,   1, 0, 0, 1, 8'hB0, 4'd1);
        add(0, 8'h00, 0,   1, 0, 0, 0, 8'h00, 4'd0);

        for (int i = 0; i < vq.size(); i++) begin
            in_if.valid  = vq[i].iv;
            in_if.data   = vq[i].d;
            out_if.ready = vq[i].ordy;
            #1;
            check($sformatf("vec%0d_in_ready", i),  32'(in_if.ready),  32'(vq[i].ir));
            check($sformatf("vec%0d_mem_we", i),    32'(mem_we),       32'(vq[i].we));
            check($sformatf("vec%0d_mem_re", i),    32'(mem_re),       32'(vq[i].re));
            check($sformatf("vec%0d_out_valid", i), 32'(out_if.valid), 32'(vq[i].ov));
            check($sformatf("vec%0d_level", i),     32'(level),        32'(vq[i].lvl));
            if (vq[i].ov) begin
                check($sformatf("vec%0d_out_data", i), 32'(out_if.data), 32'(vq[i].od));
            end
            next_cycle();
        end

        // ---------------- streaming 20 words, both sides always ready ----------------
        for (int c = 0; c < 24; c++) begin
            in_if.valid  = (c < 20);
            in_if.data   = 8'(8'h30 + c);
            out_if.ready = 1'b1;
            #1;
            if (c < 20) check($sformatf("stream%0d_in_ready", c), 32'(in_if.ready), 32'd1);
            if (c >= 3 && c < 23) begin
                check($sformatf("stream%0d_out_valid", c), 32'(out_if.valid), 32'd1);
                check($sformatf("stream%0d_out_data", c), 32'(out_if.data), 32'(8'(8'h30 + c - 3)));
            end else begin
                check($sformatf("stream%0d_out_valid", c), 32'(out_if.valid), 32'd0);
            end
            next_cycle();
        end
        check("stream_level_end", 32'(level), 32'd0);

        // ---------------- random traffic against a scoreboard ----------------
        do_reset();
        sb.delete();
        for (int c = 0; c < 1000; c++) begin
            in_if.valid  = 1'($urandom_range(0, 1));
            in_if.data   = 8'($urandom_range(0, 255));
            out_if.ready = 1'($urandom_range(0, 1));
            #1;
            check($sformatf("rand%0d_level", c), 32'(level), 32'(sb.size()));
            if (out_if.valid && out_if.ready) begin
                if (sb.size() == 0) begin
                    check($sformatf("rand%0d_pop_nonempty", c), 32'(sb.size()), 32'd1);
                end else begin
                    check($sformatf("rand%0d_out_data", c), 32'(out_if.data), 32'(sb[0]));
                    void'(sb.pop_front());
                end
            end
            if (in_if.valid && in_if.ready) sb.push_back(in_if.data);
            next_cycle();
        end

        // ---------------- reset in the middle of operation ----------------
        do_reset();
        for (int c = 0; c < 5; c++) begin
            in_if.valid  = 1'b1;
            in_if.data   = 8'(8'hC0 + c);
            out_if.ready = 1'b0;
            next_cycle();
        end
        in_if.valid = 1'b0;
        #1;
        check("midreset_level_before", 32'(level), 32'd5);
        in_if.valid  = 1'b1;
        in_if.data   = 8'hDD;
        out_if.ready = 1'b1;
        rstn         = 1'b0;
        #1;
        check_reset_outputs("midreset");
        in_if.valid  = 1'b0;
        out_if.ready = 1'b0;
        next_cycle();
        check_reset_outputs("midreset_held");
        #1;
        rstn = 1'b1;
        next_cycle();
        check("midreset_in_ready", 32'(in_if.ready), 32'd1);
        check("midreset_no_capture", 32'(out_if.valid), 32'd0);
        in_if.valid = 1'b1;
        in_if.data  = 8'h5A;
        next_cycle();
        in_if.valid  = 1'b0;
        out_if.ready = 1'b1;
        seen = 1'b0;
        exp_word = 8'h5A;
        for (int c = 0; c < 10 && !seen; c++) begin
            #1;
            if (out_if.valid) begin
                seen = 1'b1;
                check("midreset_first_word", 32'(out_if.data), 32'(exp_word));
            end
            next_cycle();
        end
        check("midreset_word_seen", 32'(seen), 32'd1);
        #1;
        check("midreset_level_end", 32'(level), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fifo_ctrl
